// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory model:
// reset instruction, fetch FSM states and byte-address decode helpers.
package mem_pkg;

  // Instruction returned during reset and for faulting fetches (addi x0,x0,0).
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fetch_state_e;

  // True when every address bit above the word index is zero.
  function automatic logic in_range(input logic [31:0] addr, input int unsigned aw);
    return (addr >> (aw + 2)) == 32'd0;
  endfunction

  // Word index addr[aw+1:2], zero-extended to 32 bits.
  function automatic logic [31:0] word_idx(input logic [31:0] addr, input int unsigned aw);
    return (addr >> 2) & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// Fixed-latency valid+data shift pipeline with synchronous flush.
// Stage 0 captures the input at the clock edge; the last stage is the output,
// so data appears DEPTH edges after it is presented.
module mem_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q [DEPTH];
  logic [WIDTH-1:0] data_q  [DEPTH];

  // Shift every stage forward each cycle; reset empties the whole pipeline.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value and the shift is order-independent.
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      valid_q[0] <= in_valid;
      data_q[0]  <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/banked_sram_model.sv
// Unified memory model: one word array shared by an instruction-fetch port
// (req/ready handshake with IWAIT wait states) and an active-low SRAM data
// port with RD_LAT-cycle pipelined reads. Both ports read the pre-edge word,
// so a same-cycle data write is never visible to a same-cycle read.
module banked_sram_model
  import mem_pkg::*;
#(
  parameter int              ADDR_W    = 22,
  parameter int              DATA_W    = 32,
  parameter int              RD_LAT    = 1,
  parameter int              IWAIT     = 0,
  parameter logic [DATA_W-1:0] RST_INSTR = DATA_W'(NOP),
  localparam int             NB        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inst_req,
  input  logic [31:0]       inst_addr,
  output logic [DATA_W-1:0] instruction,
  output logic              inst_ready,
  output logic              inst_err,
  input  logic              sram_cen,
  input  logic              sram_wen,
  input  logic [NB-1:0]     sram_ben,
  input  logic [31:0]       sram_addr,
  input  logic [DATA_W-1:0] sram_din,
  output logic [DATA_W-1:0] sram_dout,
  output logic              sram_valid,
  output logic              data_err
);

  if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr_w
    $fatal(1, "banked_sram_model: ADDR_W=%0d outside 1..30", ADDR_W);
  end
  if (DATA_W < 8 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $fatal(1, "banked_sram_model: DATA_W=%0d is not a positive multiple of 8", DATA_W);
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $fatal(1, "banked_sram_model: RD_LAT=%0d outside 1..4", RD_LAT);
  end
  if (IWAIT < 0 || IWAIT > 15) begin : g_bad_iwait
    $fatal(1, "banked_sram_model: IWAIT=%0d outside 0..15", IWAIT);
  end

  localparam logic [3:0] IWAIT_CNT = 4'(IWAIT);

  // NOTE: the array is deliberately never reset; contents survive rst_n and
  // are preloaded from outside.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // ---------------------------------------------------------------- data port
  logic              d_acc;
  logic              d_in_range;
  logic [ADDR_W-1:0] d_idx;
  logic [DATA_W-1:0] d_rd;
  logic              pipe_valid;
  logic [DATA_W:0]   pipe_data;

  assign d_acc      = !sram_cen;
  assign d_in_range = in_range(sram_addr, ADDR_W);
  assign d_idx      = ADDR_W'(word_idx(sram_addr, ADDR_W));

  // Pre-write word for every accepted in-range access; zero otherwise.
  always_comb begin
    d_rd = '0;
    if (d_acc && d_in_range) d_rd = mem[d_idx];
  end

  // Byte-lane write; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (d_acc && !sram_wen && d_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (!sram_ben[i]) mem[d_idx][8*i +: 8] <= sram_din[8*i +: 8];
      end
    end
  end

  mem_lat_pipe #(
    .DEPTH (RD_LAT),
    .WIDTH (DATA_W + 1)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (d_acc),
    .in_data   ({d_acc && !d_in_range, d_rd}),
    .out_valid (pipe_valid),
    .out_data  (pipe_data)
  );

  assign sram_valid = pipe_valid;
  assign data_err   = pipe_data[DATA_W];
  assign sram_dout  = pipe_data[DATA_W-1:0];

  // --------------------------------------------------------------- fetch port
  fetch_state_e      state_q, state_d;
  logic [3:0]        cnt_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] instr_q;
  logic              err_q;
  logic              f_accept;
  logic [31:0]       f_addr;
  logic              f_ok;
  logic [ADDR_W-1:0] f_idx;

  // Next state: accept a request from IDLE or RESP; count down wait states.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_d  = state_q;
    f_accept = 1'b0;
    f_addr   = addr_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (inst_req) begin
          f_accept = 1'b1;
          f_addr   = inst_addr;
          state_d  = (IWAIT > 0) ? WAIT : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address used for the word read on entry to RESP.
  assign f_ok  = in_range(f_addr, ADDR_W) && (f_addr[1:0] == 2'b00);
  assign f_idx = ADDR_W'(word_idx(f_addr, ADDR_W));

  // State register plus fetch datapath: latch address, count, capture word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      instr_q <= RST_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (f_accept) begin
        addr_q <= inst_addr;
        cnt_q  <= IWAIT_CNT;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (state_d == RESP) begin
        instr_q <= f_ok ? mem[f_idx] : RST_INSTR;
        err_q   <= !f_ok;
      end
    end
  end

  // Handshake outputs are a pure function of the current state.
  always_comb begin
    inst_ready = (state_q == RESP);
    inst_err   = (state_q == RESP) && err_q;
  end

  assign instruction = instr_q;

endmodule

// File: tb/tb_banked_sram_model.sv
// Bench for banked_sram_model. Two instances share clk/rst_n:
//   dut_a: RD_LAT=3, IWAIT=2  (data-port scenarios, wait-state fetches)
//   dut_b: RD_LAT=1, IWAIT=0  (back-to-back fetches, collisions)
// Reference: word arrays for the low 64 words plus a queue of expected data
// responses, each entry consumed RD_LAT cycles after it was issued.
module tb_banked_sram_model;

  localparam int          LAT_A = 3;
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // dut_a signals
  logic        a_req = 1'b0;
  logic [31:0] a_iaddr = '0;
  logic [31:0] a_instr;
  logic        a_ready, a_ierr;
  logic        a_cen = 1'b1, a_wen = 1'b1;
  logic [3:0]  a_ben = 4'hF;
  logic [31:0] a_addr = '0, a_din = '0;
  logic [31:0] a_dout;
  logic        a_valid, a_err;

  // dut_b signals
  logic        b_req = 1'b0;
  logic [31:0] b_iaddr = '0;
  logic [31:0] b_instr;
  logic        b_ready, b_ierr;
  logic        b_cen = 1'b1, b_wen = 1'b1;
  logic [3:0]  b_ben = 4'hF;
  logic [31:0] b_addr = '0, b_din = '0;
  logic [31:0] b_dout;
  logic        b_valid, b_err;

  banked_sram_model #(.RD_LAT(LAT_A), .IWAIT(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .inst_req(a_req), .inst_addr(a_iaddr), .instruction(a_instr),
    .inst_ready(a_ready), .inst_err(a_ierr),
    .sram_cen(a_cen), .sram_wen(a_wen), .sram_ben(a_ben), .sram_addr(a_addr),
    .sram_din(a_din), .sram_dout(a_dout), .sram_valid(a_valid), .data_err(a_err)
  );

  banked_sram_model #(.RD_LAT(1), .IWAIT(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .inst_req(b_req), .inst_addr(b_iaddr), .instruction(b_instr),
    .inst_ready(b_ready), .inst_err(b_ierr),
    .sram_cen(b_cen), .sram_wen(b_wen), .sram_ben(b_ben), .sram_addr(b_addr),
    .sram_din(b_din), .sram_dout(b_dout), .sram_valid(b_valid), .data_err(b_err)
  );

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } rsp_t;

  logic [31:0] mdl_a [64];
  logic [31:0] mdl_b [64];
  rsp_t        exp_q [$];
  logic [31:0] last_a, last_b;
  int          n_checks = 0;
  int          n_errors = 0;

  // With ADDR_W=22 an address is in range when bits 31:24 are zero.
  function automatic bit addr_ok(input logic [31:0] a);
    return a[31:24] == 8'h00;
  endfunction

  function automatic bit fetch_ok(input logic [31:0] a);
    return addr_ok(a) && a[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = {8'($urandom_range(1, 255)), 24'($urandom)};
    else                           a = {24'h0, 8'($urandom)};
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic refill_queue();
    rsp_t idle;
    idle = '0;
    exp_q.delete();
    for (int i = 0; i < LAT_A - 1; i++) exp_q.push_back(idle);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    a_req = 1'b0; a_cen = 1'b1; b_req = 1'b0; b_cen = 1'b1;
    tick();
    tick();
    rst_n  = 1'b1;
    last_a = NOP_I;
    last_b = NOP_I;
    refill_queue();
  endtask

  // One data-port cycle on dut_a: the reference computes the response from
  // the pre-write array, then applies the write; the queue head is compared.
  task automatic step_a(input string tag, input logic cen, input logic wen,
                        input logic [3:0] ben, input logic [31:0] addr,
                        input logic [31:0] din);
    rsp_t r;
    int   w;
    a_cen = cen; a_wen = wen; a_ben = ben; a_addr = addr; a_din = din;
    w   = int'(addr[7:2]);
    r.v = !cen;
    r.e = !cen && !addr_ok(addr);
    r.d = (!cen && addr_ok(addr)) ? mdl_a[w] : 32'h0;
    if (!cen && !wen && addr_ok(addr)) begin
      for (int i = 0; i < 4; i++)
        if (!ben[i]) mdl_a[w][8*i +: 8] = din[8*i +: 8];
    end
    exp_q.push_back(r);
    tick();
    r = exp_q.pop_front();
    n_checks++;
    if ({a_valid, a_err, a_dout} !== {r.v, r.e, r.d}) begin
      n_errors++;
      $display("FAIL %s: valid/err/dout got %0b/%0b/%h want %0b/%0b/%h",
               tag, a_valid, a_err, a_dout, r.v, r.e, r.d);
    end
  endtask

  task automatic idle_a(input string tag, input int n);
    for (int i = 0; i < n; i++) step_a(tag, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0);
  endtask

  // dut_a fetch with IWAIT=2: response exactly 3 cycles after acceptance;
  // a different address (and req) presented during WAIT must be ignored.
  task automatic fetch_a(input string tag, input logic [31:0] addr,
                         input logic [31:0] noise);
    logic [31:0] want;
    want  = fetch_ok(addr) ? mdl_a[int'(addr[7:2])] : NOP_I;
    a_req = 1'b1; a_iaddr = addr;
    tick();
    a_iaddr = noise;
    for (int c = 1; c <= 2; c++) begin
      n_checks++;
      if ({a_ready, a_instr} !== {1'b0, last_a}) begin
        n_errors++;
        $display("FAIL %s wait%0d: ready/instr got %0b/%h want 0/%h",
                 tag, c, a_ready, a_instr, last_a);
      end
      tick();
    end
    n_checks++;
    if ({a_ready, a_ierr, a_instr} !== {1'b1, !fetch_ok(addr), want}) begin
      n_errors++;
      $display("FAIL %s resp: ready/err/instr got %0b/%0b/%h want 1/%0b/%h",
               tag, a_ready, a_ierr, a_instr, !fetch_ok(addr), want);
    end
    last_a = want;
    a_req  = 1'b0;
    tick();
    n_checks++;
    if ({a_ready, a_ierr, a_instr} !== {1'b0, 1'b0, last_a}) begin
      n_errors++;
      $display("FAIL %s after: ready/err/instr got %0b/%0b/%h want 0/0/%h",
               tag, a_ready, a_ierr, a_instr, last_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({a_instr, a_ready, a_ierr, a_dout, a_valid, a_err} !== {NOP_I, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_a: instr/ready/ierr/dout/valid/err got %h/%0b/%0b/%h/%0b/%0b want %h/0/0/0/0/0",
               a_instr, a_ready, a_ierr, a_dout, a_valid, a_err, NOP_I);
    end
    n_checks++;
    if ({b_instr, b_ready, b_ierr, b_dout, b_valid, b_err} !== {NOP_I, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_b: instr/ready/ierr/dout/valid/err got %h/%0b/%0b/%h/%0b/%0b want %h/0/0/0/0/0",
               b_instr, b_ready, b_ierr, b_dout, b_valid, b_err, NOP_I);
    end
    apply_reset();
  endtask

  task automatic test_data_basic();
    step_a("wr_deadbeef", 1'b0, 1'b0, 4'h0, 32'h10, 32'hDEAD_BEEF);
    step_a("rd_deadbeef", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    idle_a("lat3_slots", LAT_A + 1);
  endtask

  task automatic test_byte_lanes();
    dut_a.mem[8] <= 32'h1122_3344;
    mdl_a[8] = 32'h1122_3344;
    step_a("lanes_wr", 1'b0, 1'b0, 4'b1010, 32'h20, 32'hAABB_CCDD);
    step_a("lanes_rd", 1'b0, 1'b1, 4'hF, 32'h20, 32'h0);
    idle_a("lanes_flush", LAT_A);
  endtask

  task automatic test_read_before_write();
    dut_a.mem[12] <= 32'd5;
    mdl_a[12] = 32'd5;
    step_a("rbw_same", 1'b0, 1'b0, 4'h0, 32'h30, 32'd9);
    step_a("rbw_next", 1'b0, 1'b1, 4'h0, 32'h30, 32'h0);
    idle_a("rbw_flush", LAT_A);
  endtask

  task automatic test_data_err();
    step_a("oor_rd", 1'b0, 1'b1, 4'h0, 32'h4000_0000, 32'h0);
    step_a("oor_wr", 1'b0, 1'b0, 4'h0, 32'h4000_0010, 32'h0BAD_0BAD);
    step_a("oor_chk", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    idle_a("oor_flush", LAT_A);
  endtask

  task automatic test_data_random();
    for (int i = 0; i < 300; i++)
      step_a("rand_data", $urandom_range(0, 3) == 0, 1'($urandom), 4'($urandom),
             rand_addr(), $urandom);
    idle_a("rand_flush", LAT_A);
  endtask

  task automatic test_fetch_wait();
    dut_a.mem[1] <= 32'h0050_0093;
    mdl_a[1] = 32'h0050_0093;
    fetch_a("fetch_wait", 32'h4, 32'h8);
  endtask

  task automatic test_fetch_err();
    fetch_a("fetch_misal", 32'h6, 32'h4);
    fetch_a("fetch_oor", 32'h4000_0000, 32'h4);
    fetch_a("fetch_ok", 32'h10, 32'h6);
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    b_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_iaddr = 32'(4 * k);
      want    = mdl_b[k];
      tick();
      n_checks++;
      if ({b_ready, b_ierr, b_instr} !== {1'b1, 1'b0, want}) begin
        n_errors++;
        $display("FAIL b2b_%0d: ready/err/instr got %0b/%0b/%h want 1/0/%h",
                 k, b_ready, b_ierr, b_instr, want);
      end
      last_b = want;
    end
    b_req = 1'b0;
    tick();
    n_checks++;
    if ({b_ready, b_instr} !== {1'b0, last_b}) begin
      n_errors++;
      $display("FAIL b2b_end: ready/instr got %0b/%h want 0/%h", b_ready, b_instr, last_b);
    end
  endtask

  task automatic test_fetch_random();
    logic        req;
    logic [31:0] addr;
    logic [31:0] want;
    for (int i = 0; i < 150; i++) begin
      req  = $urandom_range(0, 3) != 0;
      addr = rand_addr();
      b_req = req; b_iaddr = addr;
      if (req) begin
        want   = fetch_ok(addr) ? mdl_b[int'(addr[7:2])] : NOP_I;
        last_b = want;
      end
      tick();
      n_checks++;
      if ({b_ready, b_ierr, b_instr} !== {req, req && !fetch_ok(addr), last_b}) begin
        n_errors++;
        $display("FAIL rand_fetch addr=%h: ready/err/instr got %0b/%0b/%h want %0b/%0b/%h",
                 addr, b_ready, b_ierr, b_instr, req, req && !fetch_ok(addr), last_b);
      end
    end
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    logic [31:0] old_w, new_w;
    old_w = mdl_b[16];
    new_w = ~old_w;
    b_req = 1'b1; b_iaddr = 32'h40;
    b_cen = 1'b0; b_wen = 1'b0; b_ben = 4'h0; b_addr = 32'h40; b_din = new_w;
    tick();
    mdl_b[16] = new_w;
    n_checks++;
    if ({b_ready, b_instr, b_valid, b_dout} !== {1'b1, old_w, 1'b1, old_w}) begin
      n_errors++;
      $display("FAIL collide_old: ready/instr/valid/dout got %0b/%h/%0b/%h want 1/%h/1/%h",
               b_ready, b_instr, b_valid, b_dout, old_w, old_w);
    end
    b_cen = 1'b1; b_wen = 1'b1;
    tick();
    last_b = new_w;
    n_checks++;
    if ({b_ready, b_instr, b_valid} !== {1'b1, new_w, 1'b0}) begin
      n_errors++;
      $display("FAIL collide_new: ready/instr/valid got %0b/%h/%0b want 1/%h/0",
               b_ready, b_instr, b_valid, new_w);
    end
    b_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    // Fetch accepted and a data read issued, then reset lands during WAIT.
    a_req = 1'b1; a_iaddr = 32'h10;
    a_cen = 1'b0; a_wen = 1'b1; a_addr = 32'h10;
    tick();
    a_req = 1'b0; a_cen = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    last_a = NOP_I;
    last_b = NOP_I;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({a_ready, a_valid, a_instr} !== {1'b0, 1'b0, NOP_I}) begin
        n_errors++;
        $display("FAIL rst_mid_%0d: ready/valid/instr got %0b/%0b/%h want 0/0/%h",
                 c, a_ready, a_valid, a_instr, NOP_I);
      end
      tick();
    end
    refill_queue();
    fetch_a("rst_keep_fetch", 32'h10, 32'h0);
    step_a("rst_keep_data", 1'b0, 1'b1, 4'h0, 32'h10, 32'h0);
    idle_a("rst_keep_flush", LAT_A);
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dut_a.mem[i] <= v;
      mdl_a[i] = v;
      v = $urandom;
      dut_b.mem[i] <= v;
      mdl_b[i] = v;
    end
    @(negedge clk);
    test_reset();
    test_data_basic();
    test_byte_lanes();
    test_read_before_write();
    test_data_err();
    test_data_random();
    test_fetch_wait();
    test_fetch_err();
    test_back_to_back();
    test_fetch_random();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/banked_sram_model.md
Name: banked_sram_model

Overview:
- Parametrised unified memory model serving the RV32E core's instruction fetch port and its active-low SRAM data port from one shared word array.
- Successor to the fixed 1-cycle SRAM/instruction models: adds configurable data read latency, an instruction-fetch wait-state FSM with a req/ready handshake, address-range and alignment error reporting, and defined collision rules.
- Sits between the core and the bench; the bench preloads contents hierarchically.

Parameters:
- ADDR_W, 22, word-address bits; array depth 2**ADDR_W words.
- DATA_W, 32, word width; multiple of 8.
- NB, DATA_W/8, byte lanes (derived, not overridable).
- RD_LAT, 1, data-port read latency in cycles; legal range 1..4.
- IWAIT, 0, extra wait cycles per instruction fetch; legal range 0..15.
- RST_INSTR, 32'h00000013, instruction value driven in reset and on error (NOP).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- inst_req  in  1  fetch request.
- inst_addr  in  32  byte address of the fetch.
- instruction  out  DATA_W  fetched word; valid only when inst_ready=1.
- inst_ready  out  1  one-cycle pulse marking a completed fetch.
- inst_err  out  1  pulses with inst_ready when the fetch was misaligned or out of range.
- sram_cen  in  1  chip enable, active-low.
- sram_wen  in  1  write enable, active-low.
- sram_ben  in  NB  byte enables, active-low.
- sram_addr  in  32  byte address.
- sram_din  in  DATA_W  write data.
- sram_dout  out  DATA_W  read data, RD_LAT cycles after the access.
- sram_valid  out  1  high alongside sram_dout for accesses issued with cen=0.
- data_err  out  1  high alongside sram_valid when the access was out of range.

Behaviour:
- Address decode:
  - word index = addr[ADDR_W+1:2];
  - out of range when any of addr[31:ADDR_W+2] is nonzero;
  - data port ignores addr[1:0].
- Reset (rst_n=0 at posedge):
  - instruction=RST_INSTR; inst_ready=0; inst_err=0;
  - sram_dout=0; sram_valid=0; data_err=0;
  - latency pipeline flushed; fetch FSM to IDLE;
  - memory array NOT cleared.
- Data port:
  - Accesses are accepted every cycle cen=0 and are fully pipelined; there is no backpressure.
  - Write when wen=0: each lane i with ben[i]=0 updates bits [8i+7:8i] at the posedge.
  - Every accepted access, write or read, also reads the word.
  - Read-before-write: same-cycle read data is the pre-write word.
  - The read word enters an RD_LAT-deep pipeline and appears on sram_dout RD_LAT cycles later with sram_valid=1.
  - cen=1 slots propagate as sram_dout=0, sram_valid=0.
  - Out of range: write suppressed; dout=0; valid=1; data_err=1.
- Fetch FSM, states IDLE, WAIT, RESP:
  - IDLE: inst_req=1 latches addr_q and sets cnt=IWAIT. Next state is WAIT if IWAIT>0, else RESP.
  - WAIT: cnt decrements each cycle; at cnt=1 go to RESP. inst_req and inst_addr are ignored in WAIT.
  - RESP (one cycle):
    - instruction = mem[addr_q] read at RESP entry; inst_ready=1;
    - if inst_req=1, latch the new address and continue as from IDLE (back-to-back);
    - otherwise go to IDLE.
  - With IWAIT=0 and inst_req held high: one fetch per cycle, 1-cycle latency.
  - instruction holds its last value outside RESP; inst_ready=0 outside RESP.
  - Fetch error: misaligned (addr_q[1:0]!=0) or out of range gives instruction=RST_INSTR and inst_err=1 during RESP.
- Collisions:
  - A data write and a fetch read of the same word in the same cycle return the old word to the fetch.
  - The data write completes.
- Reset mid-operation: pipeline contents are discarded, and an outstanding fetch is dropped with no inst_ready.
- Parameters outside their legal range cause an elaboration-time $fatal.

Decomposition:
- Shared package mem_pkg:
  - NOP constant;
  - fetch_state_e enum {IDLE, WAIT, RESP};
  - function in_range(addr, ADDR_W);
  - function word_idx(addr, ADDR_W).
- One sub-module: mem_lat_pipe, parametrised by DEPTH and WIDTH. It is a valid+data shift pipeline with synchronous flush, instantiated for the data port with DEPTH=RD_LAT.

Test Plan:
- RD_LAT=3. Write 0xDEADBEEF at addr 0x10 with ben=0000, then read 0x10 the next cycle. Expect sram_valid and dout=0xDEADBEEF exactly 3 cycles after the read; dout=0, valid=0 in the idle slots.
- Byte lanes: preload 0x11223344 at 0x20. Write din=0xAABBCCDD with ben=1010, then read. Expect 0x11BB33DD.
- Same-cycle read+write to 0x30 (old value 5, new value 9): the same access returns 5; the next read returns 9.
- IWAIT=2, inst_req pulsed with addr 0x4 holding 0x00500093: inst_ready pulses exactly 3 cycles after acceptance with instruction=0x00500093. A changed inst_addr during WAIT is ignored.
- IWAIT=0, inst_req held high, addresses 0x0, 0x4, 0x8: three consecutive inst_ready pulses returning the three words in order.
- Error and reset cases:
  - Fetch at 0x6 gives inst_err=1 with instruction=0x13.
  - Data read at 1<<30 (ADDR_W=22) gives data_err=1 and dout=0.
  - rst_n=0 during WAIT gives no inst_ready, and the memory retains 0xDEADBEEF at 0x10.
